// File: rtl/reg_access_seq.sv
// Register-file access sequencer: turns operand fetches and word/byte writebacks
// into one-cycle regfile bus accesses, then pulses rsp_valid for the control unit.
module reg_access_seq #(
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 4,
    parameter int REGNUM_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_rd,
    input  logic [IDX_W-1:0]    src_num,
    input  logic [IDX_W-1:0]    dst_num,
    input  logic                src_const,
    input  logic                wb_byte,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [DATA_W-1:0]   src_val,
    output logic [DATA_W-1:0]   dst_val,
    output logic                rsp_valid,
    output logic [REGNUM_W-1:0] rf_regnum,
    output logic                rf_rw,
    output logic [DATA_W-1:0]   rf_wdata,
    input  logic [DATA_W-1:0]   rf_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_SRC,
        RD_DST,
        WB_RD,
        WB_WR,
        DONE
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    dst_q;
    logic [7:0]          wb_lo_q;
    logic [DATA_W-1:0]   src_val_q;
    logic [DATA_W-1:0]   dst_val_q;
    logic                rsp_valid_q;
    logic [REGNUM_W-1:0] rf_regnum_q;
    logic                rf_rw_q;
    logic [DATA_W-1:0]   rf_wdata_q;

    // XM-23 constant table, indexed by the low three bits of src_num.
    function automatic logic [DATA_W-1:0] const_val(input logic [2:0] idx);
        case (idx)
            3'd0:    return DATA_W'(16'h0000);
            3'd1:    return DATA_W'(16'h0001);
            3'd2:    return DATA_W'(16'h0002);
            3'd3:    return DATA_W'(16'h0004);
            3'd4:    return DATA_W'(16'h0008);
            3'd5:    return DATA_W'(16'h0010);
            3'd6:    return DATA_W'(16'h0020);
            default: return DATA_W'(16'hFFFF);
        endcase
    endfunction

    assign req_ready = (state_q == IDLE);
    assign src_val   = src_val_q;
    assign dst_val   = dst_val_q;
    assign rsp_valid = rsp_valid_q;
    assign rf_regnum = rf_regnum_q;
    assign rf_rw     = rf_rw_q;
    assign rf_wdata  = rf_wdata_q;

    // Bus outputs are loaded one edge ahead of the state that uses them, so
    // rf_rw/rf_regnum/rf_wdata come straight from flops and never glitch.
    // NOTE: every register here is written with <= so all updates of one edge
    // see the pre-edge values; a blocking = would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dst_q       <= '0;
            wb_lo_q     <= '0;
            src_val_q   <= '0;
            dst_val_q   <= '0;
            rsp_valid_q <= 1'b0;
            rf_regnum_q <= '0;
            rf_rw_q     <= 1'b0;
            rf_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        dst_q   <= dst_num;
                        wb_lo_q <= wb_data[7:0];
                        if (req_rd) begin
                            if (src_const) begin
                                src_val_q   <= const_val(src_num[2:0]);
                                rf_regnum_q <= REGNUM_W'(dst_num);
                                state_q     <= RD_DST;
                            end else begin
                                rf_regnum_q <= REGNUM_W'(src_num);
                                state_q     <= RD_SRC;
                            end
                        end else begin
                            rf_regnum_q <= REGNUM_W'(dst_num);
                            if (wb_byte) begin
                                state_q <= WB_RD;
                            end else begin
                                rf_wdata_q <= wb_data;
                                rf_rw_q    <= 1'b1;
                                state_q    <= WB_WR;
                            end
                        end
                    end
                end
                RD_SRC: begin
                    src_val_q   <= rf_rdata;
                    rf_regnum_q <= REGNUM_W'(dst_q);
                    state_q     <= RD_DST;
                end
                RD_DST: begin
                    dst_val_q   <= rf_rdata;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                WB_RD: begin
                    rf_wdata_q <= {rf_rdata[DATA_W-1:8], wb_lo_q};
                    rf_rw_q    <= 1'b1;
                    state_q    <= WB_WR;
                end
                WB_WR: begin
                    rf_rw_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    rf_rw_q     <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_seq.sv
// Self-checking bench for reg_access_seq: a behavioural regfile plus a request-level
// reference model (expected values, write effects, latencies) with randomized traffic.
module tb_reg_access_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_rd, src_const, wb_byte;
    logic [3:0]  src_num, dst_num;
    logic [15:0] wb_data, src_val, dst_val, rf_wdata, rf_rdata;
    logic        rsp_valid, rf_rw;
    logic [7:0]  rf_regnum;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_mem  [16];
    logic [15:0] ref_mem [16];
    logic [15:0] const_tbl [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0004,
                                   16'h0008, 16'h0010, 16'h0020, 16'hFFFF};
    logic [15:0] exp_src = '0;
    logic [15:0] exp_dst = '0;

    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [15:0] pl_val = '0;
    int          wr_count = 0;
    int          acc_count = 0;
    int          rsp_count = 0;
    logic [7:0]  last_wr_regnum = '0;
    logic [15:0] last_wr_data = '0;

    always #5 clk = ~clk;

    reg_access_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .src_num   (src_num),
        .dst_num   (dst_num),
        .src_const (src_const),
        .wb_byte   (wb_byte),
        .wb_data   (wb_data),
        .src_val   (src_val),
        .dst_val   (dst_val),
        .rsp_valid (rsp_valid),
        .rf_regnum (rf_regnum),
        .rf_rw     (rf_rw),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata)
    );

    // Single-port regfile: combinational read, write on the rising edge.
    always_comb rf_rdata = (rf_regnum[7:4] == 4'h0) ? rf_mem[rf_regnum[3:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (pl_en) begin
            rf_mem[pl_idx] <= pl_val;
        end else if (rf_rw === 1'b1) begin
            rf_mem[rf_regnum[3:0]] <= rf_wdata;
            wr_count       <= wr_count + 1;
            last_wr_regnum <= rf_regnum;
            last_wr_data   <= rf_wdata;
        end
        if (rst_n && req_valid && req_ready) acc_count <= acc_count + 1;
        if (rsp_valid === 1'b1) rsp_count <= rsp_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic preload(input logic [3:0] idx, input logic [15:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic garbage_fields();
        req_rd    = 1'($urandom);
        src_num   = 4'($urandom);
        dst_num   = 4'($urandom);
        src_const = 1'($urandom);
        wb_byte   = 1'($urandom);
        wb_data   = 16'($urandom);
    endtask

    // One request, entered and left at a falling edge with the DUT idle.
    task automatic do_req(input string tag, input bit rd, input logic [3:0] s,
                          input logic [3:0] d, input bit c, input bit b,
                          input logic [15:0] wd, input bit hold);
        int          exp_lat, exp_wr, lat, acc0, wr0;
        bit          got, mem_ok;
        logic [15:0] exp_wdata;
        exp_lat   = rd ? (c ? 2 : 3) : (b ? 3 : 2);
        exp_wr    = rd ? 0 : 1;
        exp_wdata = b ? {ref_mem[d][15:8], wd[7:0]} : wd;
        if (rd) begin
            exp_src = c ? const_tbl[s[2:0]] : ref_mem[s];
            exp_dst = ref_mem[d];
        end else begin
            ref_mem[d] = exp_wdata;
        end
        req_rd = rd; src_num = s; dst_num = d; src_const = c; wb_byte = b; wb_data = wd;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b expected 1", tag, req_ready);
        end
        acc0 = acc_count;
        wr0  = wr_count;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 8) begin
            garbage_fields();
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", tag, lat, got, exp_lat);
        end
        checks++;
        if (src_val !== exp_src) begin
            errors++;
            $display("FAIL %s src_val: got %h expected %h", tag, src_val, exp_src);
        end
        checks++;
        if (dst_val !== exp_dst) begin
            errors++;
            $display("FAIL %s dst_val: got %h expected %h", tag, dst_val, exp_dst);
        end
        checks++;
        if (acc_count - acc0 != 1) begin
            errors++;
            $display("FAIL %s accepts: got %0d expected 1", tag, acc_count - acc0);
        end
        checks++;
        if (wr_count - wr0 != exp_wr) begin
            errors++;
            $display("FAIL %s write_cycles: got %0d expected %0d", tag, wr_count - wr0, exp_wr);
        end
        if (!rd) begin
            checks++;
            if (last_wr_regnum !== {4'h0, d} || last_wr_data !== exp_wdata) begin
                errors++;
                $display("FAIL %s write_bus: got regnum=%h wdata=%h expected regnum=%h wdata=%h",
                         tag, last_wr_regnum, last_wr_data, {4'h0, d}, exp_wdata);
            end
        end
        mem_ok = 1'b1;
        for (int i = 0; i < 16; i++) if (rf_mem[i] !== ref_mem[i]) mem_ok = 1'b0;
        checks++;
        if (!mem_ok) begin
            errors++;
            $display("FAIL %s regfile: got R%0d=%h expected %h", tag, d, rf_mem[d], ref_mem[d]);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_rsp: got rsp_valid=%b req_ready=%b expected 0/1",
                     tag, rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (src_val !== 16'h0 || dst_val !== 16'h0 || rsp_valid !== 1'b0 ||
            rf_rw !== 1'b0 || rf_regnum !== 8'h0 || rf_wdata !== 16'h0) begin
            errors++;
            $display("FAIL %s reset_outputs: got src=%h dst=%h rsp=%b rw=%b regnum=%h wdata=%h expected all 0",
                     tag, src_val, dst_val, rsp_valid, rf_rw, rf_regnum, rf_wdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_rd = 1'b0; src_num = '0; dst_num = '0; src_const = 1'b0; wb_byte = 1'b0; wb_data = '0;
        #2;
        check_reset_outputs("reset");
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset req_ready: got %b expected 1", req_ready);
        end
        for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        preload(4'd3, 16'h1234);
        preload(4'd5, 16'hABCD);
        do_req("fetch", 1'b1, 4'd3, 4'd5, 1'b0, 1'b0, 16'h5555, 1'b0);
    endtask

    task automatic test_const_fetch();
        preload(4'd2, 16'h0042);
        do_req("const_fetch", 1'b1, 4'd7, 4'd2, 1'b1, 1'b0, 16'h0, 1'b0);
        do_req("const_fetch0", 1'b1, 4'd8, 4'd2, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_word_wb();
        do_req("word_wb", 1'b0, 4'd1, 4'd4, 1'b0, 1'b0, 16'hBEEF, 1'b0);
    endtask

    task automatic test_byte_wb();
        preload(4'd6, 16'h1234);
        do_req("byte_wb", 1'b0, 4'd0, 4'd6, 1'b0, 1'b1, 16'h77AB, 1'b0);
    endtask

    task automatic test_reset_mid_seq();
        int wr0, rsp0;
        preload(4'd6, 16'h1234);
        do_req("pre_reset_fetch", 1'b1, 4'd6, 4'd4, 1'b0, 1'b0, 16'h0, 1'b0);
        req_rd = 1'b0; dst_num = 4'd6; src_const = 1'b0; wb_byte = 1'b1; wb_data = 16'h77AB;
        req_valid = 1'b1;
        wr0  = wr_count;
        rsp0 = rsp_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_seq");
        exp_src = '0;
        exp_dst = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_count != wr0 || rsp_count != rsp0 || rf_mem[6] !== 16'h1234) begin
            errors++;
            $display("FAIL reset_mid_seq aborted: got writes=%0d rsps=%0d R6=%h expected 0/0/1234",
                     wr_count - wr0, rsp_count - rsp0, rf_mem[6]);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_seq req_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int rsp0;
        rsp0 = rsp_count;
        do_req("b2b_fetch", 1'b1, 4'd9, 4'd10, 1'b0, 1'b0, 16'h0, 1'b1);
        do_req("b2b_same", 1'b1, 4'd11, 4'd11, 1'b0, 1'b0, 16'h0, 1'b1);
        do_req("b2b_word", 1'b0, 4'd0, 4'd11, 1'b0, 1'b0, 16'hC0DE, 1'b1);
        do_req("b2b_byte", 1'b0, 4'd0, 4'd11, 1'b0, 1'b1, 16'hFF5A, 1'b1);
        do_req("b2b_const", 1'b1, 4'd5, 4'd11, 1'b1, 1'b0, 16'h0, 1'b1);
        do_req("b2b_fetch2", 1'b1, 4'd11, 4'd4, 1'b0, 1'b0, 16'h0, 1'b1);
        req_valid = 1'b0;
        checks++;
        if (rsp_count - rsp0 != 6) begin
            errors++;
            $display("FAIL b2b rsp_pulses: got %0d expected 6", rsp_count - rsp0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_req("random", 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                   1'($urandom), 16'($urandom), 1'($urandom));
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_const_fetch();
        test_word_wb();
        test_byte_wb();
        test_reset_mid_seq();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
